// File: rtl/fma_pkg.sv
// Shared types and constants for the fma issue sequencer.
//   fma_rsp_t    : one fma response (result word plus exception flags)
//   FMA_LAT_DEF  : default fma pipeline latency in cycles
//   FMA_CMD_*    : command codes carried on cmd_op / fma_req_command
package fma_pkg;

    localparam int unsigned FMA_LAT_DEF   = 4;
    localparam int unsigned FMA_DEPTH_DEF = 4;

    localparam logic [31:0] FMA_CMD_FMADD  = 32'd0;
    localparam logic [31:0] FMA_CMD_FMSUB  = 32'd1;
    localparam logic [31:0] FMA_CMD_FNMADD = 32'd2;
    localparam logic [31:0] FMA_CMD_FNMSUB = 32'd3;

    typedef struct packed {
        logic [31:0] rslt;
        logic [4:0]  flag;
    } fma_rsp_t;

endpackage

// File: rtl/fma_rsp_fifo.sv
// Response buffer: DEPTH-entry first-in first-out store of fma_rsp_t.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_i, wdata_i      push one entry (caller must not push when full_o)
//   rd_i               pop the head entry (caller must not pop when empty_o)
//   rdata_o            head entry, forced to zero while empty
//   full_o, empty_o    occupancy flags
module fma_rsp_fifo
    import fma_pkg::*;
#(
    parameter int unsigned DEPTH = FMA_DEPTH_DEF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     wr_i,
    input  fma_rsp_t wdata_i,
    input  logic     rd_i,
    output fma_rsp_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    fma_rsp_t    mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_i) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_i) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fma_issue.sv
// Initiator-side sequencer for the fma unit.
// Accepts operand triples on a valid/ready command channel, issues them to the
// fma as one-cycle request pulses, tracks in-flight operations against the
// fixed fma latency, buffers results in issue order and returns them on a
// valid/ready response channel. Keeps a sticky OR of popped exception flags.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_x/y/z          host command channel
//   fma_req, fma_req_command, fma_x/y/z            request to the fma
//   fma_rslt, fma_flag                              fma result, LAT cycles later
//   rsp_valid/rsp_ready, rsp_rslt, rsp_flag         host response channel
//   flag_acc, flag_clr                              sticky flag register + clear
//   busy                                            operations outstanding
module fma_issue
    import fma_pkg::*;
#(
    parameter int unsigned LAT   = FMA_LAT_DEF,
    parameter int unsigned DEPTH = FMA_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_op,
    input  logic [31:0] cmd_x,
    input  logic [31:0] cmd_y,
    input  logic [31:0] cmd_z,
    output logic        fma_req,
    output logic [31:0] fma_req_command,
    output logic [31:0] fma_x,
    output logic [31:0] fma_y,
    output logic [31:0] fma_z,
    input  logic [31:0] fma_rslt,
    input  logic [4:0]  fma_flag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rslt,
    output logic [4:0]  rsp_flag,
    output logic [4:0]  flag_acc,
    input  logic        flag_clr,
    output logic        busy
);

    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic           fma_req_q;
    logic [31:0]    cmd_q, x_q, y_q, z_q;
    logic [4:0]     flag_acc_q, flag_acc_d;
    logic [4:0]     pop_flag;

    logic     accept, pop;
    logic     wb_valid, fifo_wr, fifo_full, fifo_empty;
    fma_rsp_t fifo_wdata, fifo_rdata;

    // Credits cover in-flight plus buffered entries, so a freed slot only
    // becomes visible to the host one cycle after the pop.
    assign cmd_ready = (cnt_q < CNT_MAX);
    assign accept    = cmd_valid & cmd_ready;
    assign rsp_valid = ~fifo_empty;
    assign pop       = rsp_valid & rsp_ready;
    assign busy      = (cnt_q != '0);

    assign wb_valid   = vld_q[LAT-1];
    assign fifo_wr    = wb_valid & ~fifo_full;
    assign fifo_wdata = '{rslt: fma_rslt, flag: fma_flag};

    assign fma_req         = fma_req_q;
    assign fma_req_command = cmd_q;
    assign fma_x           = x_q;
    assign fma_y           = y_q;
    assign fma_z           = z_q;
    assign rsp_rslt        = fifo_rdata.rslt;
    assign rsp_flag        = fifo_rdata.flag;
    assign flag_acc        = flag_acc_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        vld_d    = '0;
        vld_d[0] = fma_req_q;
        for (int unsigned i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        // A clear still keeps the flags of the response popped on that edge.
        pop_flag   = pop ? rsp_flag : 5'd0;
        flag_acc_d = flag_clr ? pop_flag : (flag_acc_q | pop_flag);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            vld_q      <= '0;
            fma_req_q  <= 1'b0;
            cmd_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            flag_acc_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
            fma_req_q  <= accept;
            flag_acc_q <= flag_acc_d;
            if (accept) begin
                cmd_q <= cmd_op;
                x_q   <= cmd_x;
                y_q   <= cmd_y;
                z_q   <= cmd_z;
            end
        end
    end

    fma_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .wr_i    (fifo_wr),
        .wdata_i (fifo_wdata),
        .rd_i    (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
